// File: rtl/id_ex_forward_stage.sv
// id_ex_forward_stage
//   ID/EX pipeline register for the five-stage 64-bit pipeline, with
//   write-back bypass at capture, EX-stage operand forwarding and load-use
//   hazard detection. X31 is the zero register and reads as 0 on every path.
//
// Ports
//   clk, reset            pipeline clock, synchronous active-high reset
//   flush                 squash the instruction entering EX
//   id_*                  ID-stage operands, register numbers and control
//   exmem_*, memwb_*      downstream write-back candidates for forwarding
//   stall                 hold PC and IF/ID this cycle (combinational)
//   ex_*                  registered EX state and forwarded operands
//   bubble_count          saturating count of hazard/flush bubbles
module id_ex_forward_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [4:0]  id_ReadRegister1,
  input  logic [4:0]  id_ReadRegister2,
  input  logic [63:0] id_ReadData1,
  input  logic [63:0] id_ReadData2,
  input  logic [4:0]  id_Rd,
  input  logic [63:0] id_Imm,
  input  logic [63:0] id_PC,
  input  logic        id_RegWrite,
  input  logic        id_MemRead,
  input  logic        id_MemWrite,
  input  logic        id_MemToReg,
  input  logic        id_ALUSrc,
  input  logic [2:0]  id_ALUOp,
  input  logic        exmem_RegWrite,
  input  logic [4:0]  exmem_Rd,
  input  logic [63:0] exmem_Result,
  input  logic        memwb_RegWrite,
  input  logic [4:0]  memwb_Rd,
  input  logic [63:0] memwb_Data,
  output logic        stall,
  output logic        ex_valid,
  output logic [63:0] ex_OpA,
  output logic [63:0] ex_OpB,
  output logic [63:0] ex_StoreData,
  output logic [4:0]  ex_Rd,
  output logic [63:0] ex_Imm,
  output logic [63:0] ex_PC,
  output logic        ex_RegWrite,
  output logic        ex_MemRead,
  output logic        ex_MemWrite,
  output logic        ex_MemToReg,
  output logic [2:0]  ex_ALUOp,
  output logic [15:0] bubble_count
);

  localparam logic [4:0] ZERO_REG = 5'd31;

  logic        ex_valid_q,     ex_valid_d;
  logic [4:0]  ex_rs1_q,       ex_rs1_d;
  logic [4:0]  ex_rs2_q,       ex_rs2_d;
  logic [63:0] ex_data1_q,     ex_data1_d;
  logic [63:0] ex_data2_q,     ex_data2_d;
  logic [4:0]  ex_rd_q,        ex_rd_d;
  logic [63:0] ex_imm_q,       ex_imm_d;
  logic [63:0] ex_pc_q,        ex_pc_d;
  logic        ex_regwrite_q,  ex_regwrite_d;
  logic        ex_memread_q,   ex_memread_d;
  logic        ex_memwrite_q,  ex_memwrite_d;
  logic        ex_memtoreg_q,  ex_memtoreg_d;
  logic        ex_alusrc_q,    ex_alusrc_d;
  logic [2:0]  ex_aluop_q,     ex_aluop_d;
  logic [15:0] bubble_count_q, bubble_count_d;

  logic        hz;
  logic        load_bubble;
  logic [63:0] fwd1, fwd2;

  // Value seen by a source register at capture: the regfile output, unless
  // MEM/WB is writing that same register this cycle.
  function automatic logic [63:0] wb_bypass(input logic [4:0]  src,
                                            input logic [63:0] rf_data,
                                            input logic        wb_we,
                                            input logic [4:0]  wb_rd,
                                            input logic [63:0] wb_data);
    if (src == ZERO_REG)                  return 64'd0;
    else if (wb_we && (wb_rd == src))     return wb_data;
    else                                  return rf_data;
  endfunction

  // EX-stage forwarding: EX/MEM beats MEM/WB beats the latched value.
  function automatic logic [63:0] ex_fwd(input logic [4:0]  src,
                                         input logic [63:0] latched,
                                         input logic        em_we,
                                         input logic [4:0]  em_rd,
                                         input logic [63:0] em_data,
                                         input logic        wb_we,
                                         input logic [4:0]  wb_rd,
                                         input logic [63:0] wb_data);
    if (src == ZERO_REG)                  return 64'd0;
    else if (em_we && (em_rd == src))     return em_data;
    else if (wb_we && (wb_rd == src))     return wb_data;
    else                                  return latched;
  endfunction

  always_comb begin
    hz = id_valid && ex_valid_q && ex_memread_q && ex_regwrite_q &&
         (ex_rd_q != ZERO_REG) &&
         ((ex_rd_q == id_ReadRegister1) || (ex_rd_q == id_ReadRegister2));
    // Reset gates stall because EX state is undefined until the first edge.
    stall       = hz && !flush && !reset;
    load_bubble = flush || hz || !id_valid;
  end

  always_comb begin
    // Bubble defaults; sources point at X31 so the operands read 0.
    ex_valid_d     = 1'b0;
    ex_rs1_d       = ZERO_REG;
    ex_rs2_d       = ZERO_REG;
    ex_data1_d     = 64'd0;
    ex_data2_d     = 64'd0;
    ex_rd_d        = ZERO_REG;
    ex_imm_d       = 64'd0;
    ex_pc_d        = 64'd0;
    ex_regwrite_d  = 1'b0;
    ex_memread_d   = 1'b0;
    ex_memwrite_d  = 1'b0;
    ex_memtoreg_d  = 1'b0;
    ex_alusrc_d    = 1'b0;
    ex_aluop_d     = 3'd0;
    bubble_count_d = bubble_count_q;

    if (!load_bubble) begin
      ex_valid_d    = 1'b1;
      ex_rs1_d      = id_ReadRegister1;
      ex_rs2_d      = id_ReadRegister2;
      ex_data1_d    = wb_bypass(id_ReadRegister1, id_ReadData1,
                                memwb_RegWrite, memwb_Rd, memwb_Data);
      ex_data2_d    = wb_bypass(id_ReadRegister2, id_ReadData2,
                                memwb_RegWrite, memwb_Rd, memwb_Data);
      ex_rd_d       = id_Rd;
      ex_imm_d      = id_Imm;
      ex_pc_d       = id_PC;
      ex_regwrite_d = id_RegWrite;
      ex_memread_d  = id_MemRead;
      ex_memwrite_d = id_MemWrite;
      ex_memtoreg_d = id_MemToReg;
      ex_alusrc_d   = id_ALUSrc;
      ex_aluop_d    = id_ALUOp;
    end

    // Only hazard/flush bubbles are counted, not idle ID slots.
    if ((flush || hz) && (bubble_count_q != 16'hFFFF))
      bubble_count_d = bubble_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q     <= 1'b0;
      ex_rs1_q       <= ZERO_REG;
      ex_rs2_q       <= ZERO_REG;
      ex_data1_q     <= 64'd0;
      ex_data2_q     <= 64'd0;
      ex_rd_q        <= ZERO_REG;
      ex_imm_q       <= 64'd0;
      ex_pc_q        <= 64'd0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      ex_memwrite_q  <= 1'b0;
      ex_memtoreg_q  <= 1'b0;
      ex_alusrc_q    <= 1'b0;
      ex_aluop_q     <= 3'd0;
      bubble_count_q <= 16'd0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_rs1_q       <= ex_rs1_d;
      ex_rs2_q       <= ex_rs2_d;
      ex_data1_q     <= ex_data1_d;
      ex_data2_q     <= ex_data2_d;
      ex_rd_q        <= ex_rd_d;
      ex_imm_q       <= ex_imm_d;
      ex_pc_q        <= ex_pc_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_memread_q   <= ex_memread_d;
      ex_memwrite_q  <= ex_memwrite_d;
      ex_memtoreg_q  <= ex_memtoreg_d;
      ex_alusrc_q    <= ex_alusrc_d;
      ex_aluop_q     <= ex_aluop_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  always_comb begin
    fwd1 = ex_fwd(ex_rs1_q, ex_data1_q, exmem_RegWrite, exmem_Rd, exmem_Result,
                  memwb_RegWrite, memwb_Rd, memwb_Data);
    fwd2 = ex_fwd(ex_rs2_q, ex_data2_q, exmem_RegWrite, exmem_Rd, exmem_Result,
                  memwb_RegWrite, memwb_Rd, memwb_Data);
  end

  assign ex_OpA       = fwd1;
  assign ex_OpB       = ex_alusrc_q ? ex_imm_q : fwd2;
  assign ex_StoreData = fwd2;
  assign ex_valid     = ex_valid_q;
  assign ex_Rd        = ex_rd_q;
  assign ex_Imm       = ex_imm_q;
  assign ex_PC        = ex_pc_q;
  assign ex_RegWrite  = ex_regwrite_q;
  assign ex_MemRead   = ex_memread_q;
  assign ex_MemWrite  = ex_memwrite_q;
  assign ex_MemToReg  = ex_memtoreg_q;
  assign ex_ALUOp     = ex_aluop_q;
  assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_id_ex_forward_stage.sv
module tb_id_ex_forward_stage;

  logic        clk = 1'b0;
  logic        reset, flush, id_valid;
  logic [4:0]  id_ReadRegister1, id_ReadRegister2, id_Rd;
  logic [63:0] id_ReadData1, id_ReadData2, id_Imm, id_PC;
  logic        id_RegWrite, id_MemRead, id_MemWrite, id_MemToReg, id_ALUSrc;
  logic [2:0]  id_ALUOp;
  logic        exmem_RegWrite, memwb_RegWrite;
  logic [4:0]  exmem_Rd, memwb_Rd;
  logic [63:0] exmem_Result, memwb_Data;
  logic        stall, ex_valid;
  logic [63:0] ex_OpA, ex_OpB, ex_StoreData, ex_Imm, ex_PC;
  logic [4:0]  ex_Rd;
  logic        ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg;
  logic [2:0]  ex_ALUOp;
  logic [15:0] bubble_count;

  id_ex_forward_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
    .id_ReadRegister1(id_ReadRegister1), .id_ReadRegister2(id_ReadRegister2),
    .id_ReadData1(id_ReadData1), .id_ReadData2(id_ReadData2),
    .id_Rd(id_Rd), .id_Imm(id_Imm), .id_PC(id_PC),
    .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
    .id_MemWrite(id_MemWrite), .id_MemToReg(id_MemToReg),
    .id_ALUSrc(id_ALUSrc), .id_ALUOp(id_ALUOp),
    .exmem_RegWrite(exmem_RegWrite), .exmem_Rd(exmem_Rd),
    .exmem_Result(exmem_Result),
    .memwb_RegWrite(memwb_RegWrite), .memwb_Rd(memwb_Rd),
    .memwb_Data(memwb_Data),
    .stall(stall), .ex_valid(ex_valid), .ex_OpA(ex_OpA), .ex_OpB(ex_OpB),
    .ex_StoreData(ex_StoreData), .ex_Rd(ex_Rd), .ex_Imm(ex_Imm),
    .ex_PC(ex_PC), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_MemToReg(ex_MemToReg),
    .ex_ALUOp(ex_ALUOp), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [63:0] a, b, s;
    logic [4:0]  rd;
    logic        mr;
    logic [15:0] bc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic v, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] s, input logic [4:0] rd, input logic mr,
                      input logic [15:0] bc);
    exp_t e;
    e.v = v; e.a = a; e.b = b; e.s = s; e.rd = rd; e.mr = mr; e.bc = bc;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 64'(ex_valid), 64'(e.v));
      chk({tag, "_opa"},   ex_OpA, e.a);
      chk({tag, "_opb"},   ex_OpB, e.b);
      chk({tag, "_sd"},    ex_StoreData, e.s);
      chk({tag, "_rd"},    64'(ex_Rd), 64'(e.rd));
      chk({tag, "_mr"},    64'(ex_MemRead), 64'(e.mr));
      chk({tag, "_bc"},    64'(bubble_count), 64'(e.bc));
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_fwd();
    exmem_RegWrite = 0; exmem_Rd = 5'd0; exmem_Result = 64'd0;
    memwb_RegWrite = 0; memwb_Rd = 5'd0; memwb_Data = 64'd0;
  endtask

  task automatic set_id(input logic [4:0] r1, input logic [4:0] r2,
                        input logic [63:0] d1, input logic [63:0] d2,
                        input logic [4:0] rd, input logic rw, input logic mr,
                        input logic alusrc, input logic [63:0] imm);
    id_valid = 1; id_ReadRegister1 = r1; id_ReadRegister2 = r2;
    id_ReadData1 = d1; id_ReadData2 = d2; id_Rd = rd;
    id_RegWrite = rw; id_MemRead = mr; id_MemWrite = 0; id_MemToReg = mr;
    id_ALUSrc = alusrc; id_Imm = imm; id_PC = 64'h400; id_ALUOp = 3'd2;
  endtask

  initial begin
    // Reset with random inputs for two edges
    reset = 1; flush = $urandom_range(0, 1) == 1;
    id_valid = 1; id_ReadRegister1 = 5'($urandom); id_ReadRegister2 = 5'($urandom);
    id_ReadData1 = {$urandom, $urandom}; id_ReadData2 = {$urandom, $urandom};
    id_Rd = 5'($urandom); id_Imm = {$urandom, $urandom}; id_PC = {$urandom, $urandom};
    id_RegWrite = 1; id_MemRead = 1; id_MemWrite = 1; id_MemToReg = 1;
    id_ALUSrc = 0; id_ALUOp = 3'($urandom);
    clr_fwd();
    edge_step();
    edge_step();
    chk("rst_valid", 64'(ex_valid), 64'd0);
    chk("rst_opa", ex_OpA, 64'd0);
    chk("rst_opb", ex_OpB, 64'd0);
    chk("rst_bc", 64'(bubble_count), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_rd", 64'(ex_Rd), 64'd31);
    reset = 0; flush = 0;

    // Plain capture
    set_id(5'd1, 5'd2, 64'd10, 64'd20, 5'd4, 1, 0, 0, 64'd100);
    #1 chk("plain_stall", 64'(stall), 64'd0);
    push(1, 64'd10, 64'd20, 64'd20, 5'd4, 0, 16'd0);
    edge_step(); pop_check("plain");

    // ALUSrc selects immediate; store data keeps rs2
    set_id(5'd5, 5'd6, 64'd7, 64'd8, 5'd9, 1, 0, 1, 64'h55);
    push(1, 64'd7, 64'h55, 64'd8, 5'd9, 0, 16'd0);
    edge_step(); pop_check("alusrc");

    // EX/MEM priority over MEM/WB
    set_id(5'd3, 5'd10, 64'd5, 64'd6, 5'd11, 1, 0, 0, 64'd0);
    push(1, 64'h1234, 64'd6, 64'd6, 5'd11, 0, 16'd0);
    edge_step();
    exmem_RegWrite = 1; exmem_Rd = 5'd3; exmem_Result = 64'h1234;
    memwb_RegWrite = 1; memwb_Rd = 5'd3; memwb_Data = 64'h9;
    #1 pop_check("fwd_em");
    exmem_RegWrite = 0;
    #1 chk("fwd_wb_opa", ex_OpA, 64'h9);
    clr_fwd();

    // Load-use: LDUR X2, then consumer of X2
    set_id(5'd1, 5'd12, 64'd0, 64'd0, 5'd2, 1, 1, 1, 64'd8);
    push(1, 64'd0, 64'd8, 64'd0, 5'd2, 1, 16'd0);
    edge_step(); pop_check("ldur");
    set_id(5'd2, 5'd3, 64'd0, 64'd33, 5'd5, 1, 0, 0, 64'd0);
    #1 chk("lu_stall1", 64'(stall), 64'd1);
    push(0, 64'd0, 64'd0, 64'd0, 5'd31, 0, 16'd1);
    edge_step();
    exmem_RegWrite = 1; exmem_Rd = 5'd2; exmem_Result = 64'hBAD0;
    #1 pop_check("lu_bubble");
    chk("lu_stall2", 64'(stall), 64'd0);
    push(1, 64'hDEAD, 64'd33, 64'd33, 5'd5, 0, 16'd1);
    edge_step();
    clr_fwd();
    memwb_RegWrite = 1; memwb_Rd = 5'd2; memwb_Data = 64'hDEAD;
    #1 pop_check("lu_use");
    clr_fwd();

    // WB bypass at capture with stale regfile data
    set_id(5'd7, 5'd13, 64'd0, 64'd4, 5'd14, 1, 0, 0, 64'd0);
    memwb_RegWrite = 1; memwb_Rd = 5'd7; memwb_Data = 64'hABCD;
    push(1, 64'hABCD, 64'd4, 64'd4, 5'd14, 0, 16'd1);
    edge_step(); clr_fwd();
    #1 pop_check("wbbyp");

    // X31 source never forwards or bypasses
    set_id(5'd31, 5'd31, 64'h77, 64'h66, 5'd15, 1, 0, 0, 64'd0);
    memwb_RegWrite = 1; memwb_Rd = 5'd31; memwb_Data = 64'h5;
    push(1, 64'd0, 64'd0, 64'd0, 5'd15, 0, 16'd1);
    edge_step();
    exmem_RegWrite = 1; exmem_Rd = 5'd31; exmem_Result = 64'hFF;
    #1 pop_check("x31_src");
    clr_fwd();

    // Load to X31 followed by read of X31: no hazard
    set_id(5'd1, 5'd1, 64'd0, 64'd0, 5'd31, 1, 1, 0, 64'd0);
    push(1, 64'd0, 64'd0, 64'd0, 5'd31, 1, 16'd1);
    edge_step(); pop_check("ld_x31");
    set_id(5'd31, 5'd16, 64'd0, 64'd3, 5'd17, 1, 0, 0, 64'd0);
    #1 chk("x31_stall", 64'(stall), 64'd0);
    push(1, 64'd0, 64'd3, 64'd3, 5'd17, 0, 16'd1);
    edge_step(); pop_check("x31_use");

    // Flush together with a load-use hazard
    set_id(5'd1, 5'd1, 64'd0, 64'd0, 5'd2, 1, 1, 0, 64'd0);
    push(1, 64'd0, 64'd0, 64'd0, 5'd2, 1, 16'd1);
    edge_step(); pop_check("ld2");
    set_id(5'd2, 5'd3, 64'd1, 64'd2, 5'd5, 1, 0, 0, 64'd0);
    flush = 1;
    #1 chk("fl_stall", 64'(stall), 64'd0);
    push(0, 64'd0, 64'd0, 64'd0, 5'd31, 0, 16'd2);
    edge_step(); flush = 0;
    #1 pop_check("fl_hz");

    // Idle ID slot: bubble but not counted
    id_valid = 0;
    push(0, 64'd0, 64'd0, 64'd0, 5'd31, 0, 16'd2);
    edge_step(); pop_check("idle");

    // Reset in the middle of a stall
    set_id(5'd1, 5'd1, 64'd0, 64'd0, 5'd2, 1, 1, 0, 64'd0);
    edge_step();
    set_id(5'd2, 5'd2, 64'd1, 64'd1, 5'd6, 1, 0, 0, 64'd0);
    #1 chk("rs_stall_pre", 64'(stall), 64'd1);
    reset = 1;
    #1 chk("rs_stall_rst", 64'(stall), 64'd0);
    push(0, 64'd0, 64'd0, 64'd0, 5'd31, 0, 16'd0);
    edge_step(); reset = 0;
    #1 pop_check("rs_mid");

    // Saturation of bubble_count
    flush = 1;
    for (int i = 0; i < 65538; i++) @(posedge clk);
    #1 chk("sat_bc", 64'(bubble_count), 64'hFFFF);
    edge_step();
    chk("sat_hold", 64'(bubble_count), 64'hFFFF);
    flush = 0;

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_forward_stage.md
# id_ex_forward_stage

ID/EX pipeline register with operand forwarding and load-use hazard detection for the five-stage 64-bit pipelined CPU. It sits directly downstream of the register file. It captures the two read operands, the decoded control bits, the immediate and the PC at the end of ID. In EX it presents forwarded ALU operands and store data. When a load result is consumed by the very next instruction, it inserts a bubble and asserts `stall` to the upstream stages.

## Interface
Parameters: none; data width fixed at 64, register index width fixed at 5, X31 is the zero register.

Ports:
- `clk`  in  1  — pipeline clock; all state updates on the rising edge
- `reset`  in  1  — synchronous, active-high
- `flush`  in  1  — squash the instruction entering EX (taken branch)
- `id_valid`  in  1  — ID holds a real instruction
- `id_ReadRegister1`, `id_ReadRegister2`  in  5 each  — source register numbers sent to the regfile
- `id_ReadData1`, `id_ReadData2`  in  64 each  — regfile read outputs
- `id_Rd`  in  5  — destination register
- `id_Imm`, `id_PC`  in  64 each  — sign-extended immediate and instruction PC
- `id_RegWrite`, `id_MemRead`, `id_MemWrite`, `id_MemToReg`, `id_ALUSrc`  in  1 each  — decoded control
- `id_ALUOp`  in  3  — ALU operation
- `exmem_RegWrite`  in  1, `exmem_Rd`  in  5, `exmem_Result`  in  64  — EX/MEM writeback candidate
- `memwb_RegWrite`  in  1, `memwb_Rd`  in  5, `memwb_Data`  in  64  — MEM/WB writeback, the same value being written to the regfile this cycle
- `stall`  out  1  — hold PC and IF/ID this cycle (combinational)
- `ex_valid`  out  1  — EX holds a real instruction
- `ex_OpA`, `ex_OpB`, `ex_StoreData`  out  64 each  — forwarded operands (combinational from EX state)
- `ex_Rd`  out  5, `ex_Imm`, `ex_PC`  out  64 each, `ex_RegWrite`, `ex_MemRead`, `ex_MemWrite`, `ex_MemToReg`  out  1 each, `ex_ALUOp`  out  3  — registered EX copies
- `bubble_count`  out  16  — saturating count of bubbles inserted by hazard or flush

## Operation
- **Hazard:** `hz` = `id_valid` & `ex_valid` & `ex_MemRead` & `ex_RegWrite` & `ex_Rd`≠31 & (`ex_Rd`==`id_ReadRegister1` | `ex_Rd`==`id_ReadRegister2`).
- **Stall output:** `stall` = `hz` & !`flush`.
- **Capture (rising edge, `reset`=0):**
  - If `flush` | `hz` | !`id_valid`: load a bubble. `ex_valid`=0, all control bits 0, `ex_Rd`=31, data fields 0.
  - Otherwise: `ex_valid`=1 and all `id_*` fields are copied.
- **WB bypass at capture:** for each source N, if `memwb_RegWrite` & `memwb_Rd`==`id_ReadRegisterN` & `id_ReadRegisterN`≠31, latch `memwb_Data` instead of `id_ReadDataN`. This covers a same-cycle regfile write when the regfile is not clocked on the inverted edge.
- **EX forwarding (combinational):** applied to latched source N, giving `fwdN`. Priority:
  1. EX/MEM: if `exmem_RegWrite` & `exmem_Rd`==srcN & srcN≠31, use `exmem_Result`.
  2. MEM/WB: else if `memwb_RegWrite` & `memwb_Rd`==srcN & srcN≠31, use `memwb_Data`.
  3. Otherwise use the latched data.
- **Operand outputs:**
  - `ex_OpA` = `fwd1`.
  - `ex_OpB` = `ex_ALUSrc` ? `ex_Imm` : `fwd2`.
  - `ex_StoreData` = `fwd2` regardless of `ALUSrc`.
- A source register number of 31 always yields 0 from any path.
- **bubble_count:** increments by 1 on each edge that loads a bubble because of `flush` or `hz`. A bubble loaded only because `id_valid`=0 does not count. Saturates at 0xFFFF.

## Timing
- ID→EX latency is 1 cycle. Forwarded operands are valid in the same cycle as the EX state.
- **Reset:** synchronous. On the first edge with `reset`=1:
  - `ex_valid`=0, all `ex_*` control bits 0, `ex_Rd`=31, `ex_Imm`=`ex_PC`=0, latched data 0, `bubble_count`=0.
  - `stall` is 0 while `reset` is high.
- **Reset mid-stall:** reset overrides. The next cycle shows a bubble and `stall`=0.
- **Stall length:** `stall` lasts exactly one cycle per load-use pair. After the bubble `ex_MemRead`=0, so `hz` drops and the held instruction captures on the following edge, using MEM/WB or EX/MEM forwarding for the load result.
- **Flush with hazard:** `flush` and `hz` together give one bubble, `stall`=0, and `bubble_count` +1.
- **Zero register:** `ex_Rd`=31 with `RegWrite`=1 never creates a hazard and never forwards.

## Test plan
- **Reset:** `reset`=1 for 2 edges with random inputs → `ex_valid`=0, `ex_OpA`=`ex_OpB`=0, `bubble_count`=0, `stall`=0.
- **EX/MEM forward:** EX src1=X3 latched 5, `exmem_RegWrite`=1, `exmem_Rd`=3, `exmem_Result`=0x1234, and MEM/WB also Rd=3 with 0x9 → `ex_OpA`=0x1234 (EX/MEM priority).
- **Load-use:**
  - Setup: EX holds LDUR X2 (`MemRead`=1, `RegWrite`=1, Rd=2); ID reads X2.
  - Cycle 1: `stall`=1, then a bubble enters EX and `bubble_count`=1.
  - Cycle 2: `stall`=0 and the instruction enters with `ex_OpA` taking `memwb_Data`.
- **WB bypass:** ID reads X7 with `id_ReadData1`=0 (stale) while `memwb_RegWrite`=1, Rd=7, data 0xABCD → the next cycle `ex_OpA`=0xABCD with no forwarding active.
- **X31:** source X31 with `exmem_Rd`=31, `exmem_RegWrite`=1, result 0xFF → `ex_OpA`=0. A load to X31 followed by a read of X31 → `stall`=0.
- **Flush with hazard:** `flush`=1 with a load-use condition present → `stall`=0, `ex_valid`=0 next cycle, `bubble_count` +1. Force 0xFFFF bubbles → count holds at 0xFFFF.
